// File: rtl/jtframe_quadcnt_pkg.sv
// jtframe_quadcnt_pkg
// Shared definitions for the quadrature counter: the 2-bit phase state
// constants ({A,B}), the step direction encoding and the Gray-code decoder.
package jtframe_quadcnt_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2,
        DIR_ERR  = 2'd3
    } dir_e;

    // A leads B going forward: 00 -> 10 -> 11 -> 01 -> 00.
    // A single-bit change that is not the forward successor must be the reverse one.
    function automatic dir_e decode(input logic [1:0] prv, input logic [1:0] cur);
        logic [1:0] fwd;
        case (prv)
            S00:     fwd = S10;
            S10:     fwd = S11;
            S11:     fwd = S01;
            default: fwd = S00;
        endcase
        if (cur == prv)                 return DIR_NONE;
        else if ((cur ^ prv) == 2'b11)  return DIR_ERR;
        else if (cur == fwd)            return DIR_UP;
        else                            return DIR_DN;
    endfunction

endpackage

// File: rtl/jtframe_quadcnt_axis.sv
// jtframe_quadcnt_axis
// One encoder axis: two-flop synchroniser, stability filter, Gray decoder,
// wrap/saturate counter and the sticky moved / illegal flags.
//   clk, rst        clock, async active-high reset
//   a_i, b_i        encoder phases (asynchronous)
//   ax_rst_i        synchronous counter clear
//   flag_clr_i      clears cfn_o / err_o
//   cnt_o           live counter value
//   cfn_o           moved flag, active low
//   err_o           illegal-transition flag
module jtframe_quadcnt_axis
    import jtframe_quadcnt_pkg::*;
#(
    parameter int CW   = 12,
    parameter int FILT = 2,
    parameter int SAT  = 0
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          a_i,
    input  logic          b_i,
    input  logic          ax_rst_i,
    input  logic          flag_clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          cfn_o,
    output logic          err_o
);

    logic [1:0]    sync1_q, sync2_q, filt, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cfn_q, cfn_d, err_q, err_d;
    dir_e          dir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {a_i, b_i};
            sync2_q <= sync1_q;
        end
    end

    generate
        if (FILT == 0) begin : g_nofilt
            assign filt = sync2_q;
        end else begin : g_filt
            localparam int FW = $clog2(FILT + 1);
            logic [1:0]    last_q, filt_q;
            logic [FW-1:0] fcnt_q, run;

            // run = number of consecutive cycles sync2_q has held its current
            // value, including this one; saturates at FILT.
            always_comb begin
                run = FW'(1);
                if (sync2_q == last_q)
                    run = (fcnt_q == FW'(FILT)) ? fcnt_q : fcnt_q + FW'(1);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    last_q <= 2'b00;
                    fcnt_q <= '0;
                    filt_q <= 2'b00;
                end else begin
                    last_q <= sync2_q;
                    fcnt_q <= run;
                    if (run == FW'(FILT)) filt_q <= sync2_q;
                end
            end
            assign filt = filt_q;
        end
    endgenerate

    assign dir = decode(prev_q, filt);

    // Step and flag_clr in the same cycle: the step wins, so the flag stays set.
    always_comb begin
        cnt_d = cnt_q;
        cfn_d = cfn_q;
        err_d = err_q;
        if (flag_clr_i) begin
            cfn_d = 1'b1;
            err_d = 1'b0;
        end
        if (ax_rst_i) begin
            cnt_d = '0;
        end else begin
            case (dir)
                DIR_UP: begin
                    cfn_d = 1'b0;
                    if (!(SAT != 0 && cnt_q == '1)) cnt_d = cnt_q + 1'b1;
                end
                DIR_DN: begin
                    cfn_d = 1'b0;
                    if (!(SAT != 0 && cnt_q == '0)) cnt_d = cnt_q - 1'b1;
                end
                DIR_ERR: err_d = 1'b1;
                default: ;
            endcase
        end
    end

    // prev_q always follows the filtered pair, so ax_rst release never counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 2'b00;
            cnt_q  <= '0;
            cfn_q  <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            prev_q <= filt;
            cnt_q  <= cnt_d;
            cfn_q  <= cfn_d;
            err_q  <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign cfn_o = cfn_q;
    assign err_o = err_q;

endmodule

// File: rtl/jtframe_quadcnt.sv
// jtframe_quadcnt
// Multi-axis quadrature counter with coherent snapshot read-out.
//   clk, rst        clock, async active-high reset
//   a_i, b_i        encoder phases per axis
//   ax_rst_i        per-axis counter clear
//   latch_i         snapshot all axes
//   sel_i           axis routed to dout_o
//   flag_clr_i      clears cfn_o / err_o
//   dout_o          registered snapshot of the selected axis
//   cfn_o           per-axis moved flag, active low
//   err_o           per-axis illegal-transition flag
module jtframe_quadcnt
    import jtframe_quadcnt_pkg::*;
#(
    parameter int AXES = 2,
    parameter int CW   = 12,
    parameter int FILT = 2,
    parameter int SAT  = 0,
    localparam int SW  = (AXES > 1) ? $clog2(AXES) : 1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [AXES-1:0] a_i,
    input  logic [AXES-1:0] b_i,
    input  logic [AXES-1:0] ax_rst_i,
    input  logic            latch_i,
    input  logic [SW-1:0]   sel_i,
    input  logic            flag_clr_i,
    output logic [CW-1:0]   dout_o,
    output logic [AXES-1:0] cfn_o,
    output logic [AXES-1:0] err_o
);

    logic [AXES-1:0][CW-1:0] cnt, snap_q;
    logic [CW-1:0]           dout_q, dout_d;

    genvar i;
    generate
        for (i = 0; i < AXES; i++) begin : g_ax
            jtframe_quadcnt_axis #(
                .CW   (CW),
                .FILT (FILT),
                .SAT  (SAT)
            ) u_axis (
                .clk        (clk),
                .rst        (rst),
                .a_i        (a_i[i]),
                .b_i        (b_i[i]),
                .ax_rst_i   (ax_rst_i[i]),
                .flag_clr_i (flag_clr_i),
                .cnt_o      (cnt[i]),
                .cfn_o      (cfn_o[i]),
                .err_o      (err_o[i])
            );
        end
    endgenerate

    // Out-of-range selects (non power-of-two AXES) read as zero.
    always_comb begin
        dout_d = '0;
        if (32'(sel_i) < 32'(AXES)) dout_d = snap_q[sel_i];
    end

    // cnt is registered, so a latch captures the value before any step
    // decoded in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
            dout_q <= '0;
        end else begin
            if (latch_i) snap_q <= cnt;
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: tb/tb_jtframe_quadcnt.sv
module tb_jtframe_quadcnt;
    localparam int CW = 4, FILT = 2, MAXV = 15;

    logic       clk = 0, rst = 0, latch = 0, sel = 0, flag_clr = 0;
    logic [1:0] a = 0, b = 0, ax_rst = 0;
    logic [3:0] dout_w, dout_s;
    logic [1:0] cfn_w, cfn_s, err_w, err_s;

    always #5 clk = ~clk;

    jtframe_quadcnt #(.AXES(2), .CW(CW), .FILT(FILT), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b), .ax_rst_i(ax_rst), .latch_i(latch),
        .sel_i(sel), .flag_clr_i(flag_clr), .dout_o(dout_w), .cfn_o(cfn_w), .err_o(err_w));

    jtframe_quadcnt #(.AXES(2), .CW(CW), .FILT(FILT), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b), .ax_rst_i(ax_rst), .latch_i(latch),
        .sel_i(sel), .flag_clr_i(flag_clr), .dout_o(dout_s), .cfn_o(cfn_s), .err_o(err_s));

    // Reference model: encoder position expressed as an index around the
    // 4-phase cycle; movement is the index difference modulo 4.
    int         n_chk = 0, n_err = 0;
    int         cnt_w[2], cnt_s[2], snap_w[2], snap_s[2];
    logic [1:0] m_cfn, m_err;
    logic [1:0] pin[2], seen[2];

    function automatic int gidx(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gst(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive();
        a = {pin[1][1], pin[0][1]};
        b = {pin[1][0], pin[0][0]};
    endtask

    task automatic apply(input int ax);
        int d;
        d = (gidx(pin[ax]) - gidx(seen[ax]) + 4) % 4;
        if (d == 1) begin
            cnt_w[ax] = (cnt_w[ax] + 1) % (MAXV + 1);
            cnt_s[ax] = (cnt_s[ax] < MAXV) ? cnt_s[ax] + 1 : MAXV;
            m_cfn[ax] = 1'b0;
        end else if (d == 3) begin
            cnt_w[ax] = (cnt_w[ax] + MAXV) % (MAXV + 1);
            cnt_s[ax] = (cnt_s[ax] > 0) ? cnt_s[ax] - 1 : 0;
            m_cfn[ax] = 1'b0;
        end else if (d == 2) begin
            m_err[ax] = 1'b1;
        end
        seen[ax] = pin[ax];
    endtask

    task automatic settle();
        tick(6);
        apply(0);
        apply(1);
    endtask

    task automatic move(input int ax, input int d);
        pin[ax] = gst(gidx(pin[ax]) + d);
        drive();
        settle();
    endtask

    task automatic check_flags(input string tag);
        chk({tag, ".cfn_w"}, int'(cfn_w), int'(m_cfn));
        chk({tag, ".cfn_s"}, int'(cfn_s), int'(m_cfn));
        chk({tag, ".err_w"}, int'(err_w), int'(m_err));
        chk({tag, ".err_s"}, int'(err_s), int'(m_err));
    endtask

    task automatic read_snap(input string tag);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            tick(1);
            chk($sformatf("%s.dw%0d", tag, s), int'(dout_w), snap_w[s]);
            chk($sformatf("%s.ds%0d", tag, s), int'(dout_s), snap_s[s]);
        end
    endtask

    task automatic read_all(input string tag);
        latch = 1;
        tick(1);
        latch = 0;
        snap_w = cnt_w;
        snap_s = cnt_s;
        read_snap(tag);
    endtask

    task automatic clr();
        flag_clr = 1;
        tick(1);
        flag_clr = 0;
        m_cfn = 2'b11;
        m_err = 2'b00;
    endtask

    task automatic glitch(input int ax, input int len);
        logic [1:0] orig;
        orig = pin[ax];
        pin[ax] = orig ^ 2'b10;
        drive();
        tick(len);
        if (len >= FILT) apply(ax);
        pin[ax] = orig;
        drive();
        settle();
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            cnt_w[i] = 0; cnt_s[i] = 0; snap_w[i] = 0; snap_s[i] = 0;
            seen[i] = 2'b00;
        end
        m_cfn = 2'b11;
        m_err = 2'b00;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".dw"}, int'(dout_w), 0);
        chk({tag, ".ds"}, int'(dout_s), 0);
        chk({tag, ".cfn"}, int'(cfn_w), 3);
        chk({tag, ".cfns"}, int'(cfn_s), 3);
        chk({tag, ".err"}, int'(err_w), 0);
        chk({tag, ".errs"}, int'(err_s), 0);
    endtask

    initial begin
        pin[0] = 2'b00; pin[1] = 2'b00;
        reset_model();
        drive();
        #1 rst = 1;
        #1 check_reset("rst0");
        tick(3);
        rst = 0;
        tick(2);

        // Four forward phases on axis 0, with exact moved-flag latency.
        for (int k = 0; k < 4; k++) begin
            pin[0] = gst(gidx(pin[0]) + 1);
            drive();
            tick(2 + FILT);
            if (k == 0) chk("lat.cfn_early", int'(cfn_w[0]), 1);
            tick(1);
            if (k == 0) chk("lat.cfn_edge", int'(cfn_w[0]), 0);
            tick(1);
            apply(0);
        end
        chk("four.cfn", int'(cfn_w), 2'b10);
        check_flags("four");
        read_all("four");

        // Wrap vs saturate: 17 forward from 0, then one reverse.
        ax_rst[1] = 1; tick(1); ax_rst[1] = 0;
        for (int k = 0; k < 17; k++) move(1, 1);
        read_all("wrap17");
        move(1, 3);
        read_all("rev1");

        // Glitch filtering.
        clr();
        glitch(0, 1);
        check_flags("glitch1");
        read_all("glitch1");
        glitch(0, 3);
        check_flags("glitch3");
        read_all("glitch3");

        // Illegal diagonal jump.
        clr();
        move(0, 2);
        check_flags("illegal");
        read_all("illegal");

        // flag_clr coincident with a legal step.
        pin[1] = gst(gidx(pin[1]) + 1);
        drive();
        tick(2 + FILT);
        flag_clr = 1;
        tick(1);
        flag_clr = 0;
        m_cfn = 2'b11; m_err = 2'b00;
        tick(1);
        apply(1);
        check_flags("clr_step");

        // Build counts 5/9, then latch coincident with a step on both axes.
        ax_rst = 2'b11; tick(1); ax_rst = 2'b00;
        cnt_w[0] = 0; cnt_w[1] = 0; cnt_s[0] = 0; cnt_s[1] = 0;
        for (int k = 0; k < 5; k++) move(0, 1);
        for (int k = 0; k < 9; k++) move(1, 1);
        pin[0] = gst(gidx(pin[0]) + 1);
        pin[1] = gst(gidx(pin[1]) + 3);
        drive();
        tick(2 + FILT);
        latch = 1;
        tick(1);
        latch = 0;
        snap_w = cnt_w; snap_s = cnt_s;
        chk("snap.model0", snap_w[0], 5);
        tick(1);
        apply(0); apply(1);
        move(0, 1); move(1, 1);
        read_snap("hold59");
        read_all("after59");

        // ax_rst coincident with a step: cleared, no count on release.
        pin[0] = gst(gidx(pin[0]) + 1);
        drive();
        tick(2 + FILT);
        ax_rst[0] = 1;
        tick(1);
        ax_rst[0] = 0;
        cnt_w[0] = 0; cnt_s[0] = 0; seen[0] = pin[0];
        tick(4);
        check_flags("axrst");
        read_all("axrst");

        // Async reset in the middle of a transition.
        pin[0] = gst(gidx(pin[0]) + 1);
        drive();
        tick(2);
        #3 rst = 1;
        #1 check_reset("rst_mid");
        tick(2);
        rst = 0;
        reset_model();
        settle();
        check_flags("rst_post");
        read_all("rst_post");

        // Randomized operation mix.
        for (int it = 0; it < 80; it++) begin
            int op, ax;
            op = $urandom_range(0, 9);
            ax = $urandom_range(0, 1);
            case (op)
                0, 1, 2: move(ax, 1);
                3:       move(ax, 3);
                4:       move(ax, ($urandom_range(0, 3) == 0) ? 2 : 1);
                5:       glitch(ax, $urandom_range(1, 3));
                6:       clr();
                7:       read_all($sformatf("rnd%0d", it));
                8: begin
                    ax_rst[ax] = 1; tick(1); ax_rst[ax] = 0;
                    cnt_w[ax] = 0; cnt_s[ax] = 0;
                end
                default: check_flags($sformatf("rndf%0d", it));
            endcase
        end
        check_flags("final");
        read_all("final");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
